// File: rtl/io_router_pkg.sv
// rtl/io_router_pkg.sv - shared constants and helpers for the IO control router
// Purpose: LA lane base offsets, parameter limit checks, fanout bank slicing.
// Ports: none (package).
package io_router_pkg;

  localparam int LA_WIDTH        = 128;
  localparam int LA_OEB_IN_BASE  = 0;
  localparam int LA_OEB_OUT_BASE = 16;
  localparam int LA_IN_BASE      = 32;
  localparam int LA_OUT_BASE     = 48;
  localparam int MAX_IO          = 16;

  function automatic bit io_count_ok(input int n);
    return (n >= 1) && (n <= MAX_IO);
  endfunction

  function automatic bit params_ok(
    input int num_in,
    input int num_out,
    input int sync_stages,
    input int filter_len,
    input int num_banks,
    input int pipe_stages,
    input int fanout_w
  );
    return io_count_ok(num_in) && io_count_ok(num_out) &&
           (sync_stages >= 2) && (filter_len >= 1) &&
           (num_banks >= 1) && (pipe_stages >= 1) && (fanout_w >= 1);
  endfunction

  // Low bit of bank b inside the flattened fanout_out bus.
  function automatic int bank_lsb(input int bank, input int width);
    return bank * width;
  endfunction

endpackage

// File: rtl/io_control_router_if.sv
// rtl/io_control_router_if.sv - logic-analyzer override bus
// Purpose: carries the LA data/enable lanes into the router.
// Signals: la_data_in[127:0] override values, la_oenb[127:0] active-low lane enables.
interface io_control_router_if;
  import io_router_pkg::*;

  logic [LA_WIDTH-1:0] la_data_in;
  logic [LA_WIDTH-1:0] la_oenb;

  modport master (output la_data_in, output la_oenb);
  modport slave  (input  la_data_in, input  la_oenb);
endinterface

// File: rtl/io_sync_filter.sv
// rtl/io_sync_filter.sv - per-input synchronizer, glitch filter and edge pulses
// Purpose: synchronizes one pad, optionally replaces it with an LA override,
//          and only accepts a new level after FILTER_LEN consecutive cycles.
// Ports: clock, reset_n; pad (raw async input), ovr_en/ovr_val (LA override);
//        filt (filtered level), rise/fall (1-cycle pulses with filt changes).
module io_sync_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3,
  parameter bit RESET_VAL   = 1'b0
) (
  input  logic clock,
  input  logic reset_n,
  input  logic pad,
  input  logic ovr_en,
  input  logic ovr_val,
  output logic filt,
  output logic rise,
  output logic fall
);

  localparam int            CW       = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_q;
  logic [CW-1:0]          cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      s_q    <= RESET_VAL;
      cnt    <= '0;
      filt   <= RESET_VAL;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pad};
      // The override is already synchronous, so it skips the sync chain.
      s_q    <= ovr_en ? ovr_val : sync_q[SYNC_STAGES-1];
      rise   <= 1'b0;
      fall   <= 1'b0;
      if (s_q == filt) begin
        // Returning to the accepted level restarts the stability count.
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        filt <= s_q;
        cnt  <= '0;
        rise <= s_q;
        fall <= ~s_q;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/io_control_router.sv
// rtl/io_control_router.sv - pad / LA routing with filtered inputs and replicated fanout
// Purpose: registers pad OEBs and outputs with LA overrides, conditions each
//          pad input, and drives NUM_BANKS independent copies of the core bus.
// Ports: clock, reset_n; la (LA bus, slave); io_in/io_in_oeb; core_in and
//        rise/fall pulses; core_out/io_out/io_out_oeb; fanout_in/fanout_out.
module io_control_router
  import io_router_pkg::*;
#(
  parameter int                NUM_IN       = 5,
  parameter int                NUM_OUT      = 2,
  parameter int                SYNC_STAGES  = 2,
  parameter int                FILTER_LEN   = 3,
  parameter logic [NUM_IN-1:0] FILTER_MASK  = 5'b00011,
  parameter logic [NUM_IN-1:0] IN_RESET_VAL = 5'b10000,
  parameter int                FANOUT_W     = 64,
  parameter int                NUM_BANKS    = 2,
  parameter int                PIPE_STAGES  = 1
) (
  input  logic                          clock,
  input  logic                          reset_n,
  io_control_router_if.slave            la,
  input  logic [NUM_IN-1:0]             io_in,
  output logic [NUM_IN-1:0]             io_in_oeb,
  output logic [NUM_IN-1:0]             core_in,
  output logic [NUM_IN-1:0]             core_in_rise,
  output logic [NUM_IN-1:0]             core_in_fall,
  input  logic [NUM_OUT-1:0]            core_out,
  output logic [NUM_OUT-1:0]            io_out,
  output logic [NUM_OUT-1:0]            io_out_oeb,
  input  logic [FANOUT_W-1:0]           fanout_in,
  output logic [NUM_BANKS*FANOUT_W-1:0] fanout_out
);

  if (!params_ok(NUM_IN, NUM_OUT, SYNC_STAGES, FILTER_LEN,
                 NUM_BANKS, PIPE_STAGES, FANOUT_W)) begin : g_bad_params
    $error("io_control_router: parameter out of range");
  end

  // Only the low 64 LA lanes are mapped; the rest are intentionally ignored.
  logic unused_la;
  assign unused_la = ^{la.la_data_in, la.la_oenb};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      io_in_oeb  <= '1;
      io_out_oeb <= '0;
      io_out     <= '0;
    end else begin
      for (int i = 0; i < NUM_IN; i++) begin
        io_in_oeb[i] <= la.la_oenb[LA_OEB_IN_BASE + i] ? 1'b1
                                                        : la.la_data_in[LA_OEB_IN_BASE + i];
      end
      for (int j = 0; j < NUM_OUT; j++) begin
        io_out_oeb[j] <= la.la_oenb[LA_OEB_OUT_BASE + j] ? 1'b0
                                                          : la.la_data_in[LA_OEB_OUT_BASE + j];
        io_out[j]     <= la.la_oenb[LA_OUT_BASE + j] ? core_out[j]
                                                      : la.la_data_in[LA_OUT_BASE + j];
      end
    end
  end

  for (genvar i = 0; i < NUM_IN; i++) begin : g_in
    // Unmasked channels still run through the filter, just with a one-cycle window.
    io_sync_filter #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILTER_LEN  (FILTER_MASK[i] ? FILTER_LEN : 1),
      .RESET_VAL   (IN_RESET_VAL[i])
    ) u_filter (
      .clock   (clock),
      .reset_n (reset_n),
      .pad     (io_in[i]),
      .ovr_en  (~la.la_oenb[LA_IN_BASE + i]),
      .ovr_val (la.la_data_in[LA_IN_BASE + i]),
      .filt    (core_in[i]),
      .rise    (core_in_rise[i]),
      .fall    (core_in_fall[i])
    );
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    localparam int LSB = bank_lsb(b, FANOUT_W);

    // Each bank keeps its own chain so placement can put it near its drivers;
    // keep stops synthesis from merging the identical registers.
    (* keep *) logic [FANOUT_W-1:0] pipe_q [PIPE_STAGES];

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        for (int s = 0; s < PIPE_STAGES; s++) begin
          pipe_q[s] <= '0;
        end
      end else begin
        pipe_q[0] <= fanout_in;
        for (int s = 1; s < PIPE_STAGES; s++) begin
          pipe_q[s] <= pipe_q[s-1];
        end
      end
    end

    assign fanout_out[LSB +: FANOUT_W] = pipe_q[PIPE_STAGES-1];
  end

endmodule

// File: tb/tb_io_control_router.sv
// tb/tb_io_control_router.sv - directed self-checking bench for io_control_router
module tb_io_control_router;

  localparam int          NB  = 4;
  localparam int          PS  = 3;
  localparam logic [63:0] FAN = 64'hDEADBEEF_01234567;

  logic          clock;
  logic          reset_n;
  logic [4:0]    io_in;
  logic [4:0]    io_in_oeb;
  logic [4:0]    core_in;
  logic [4:0]    core_in_rise;
  logic [4:0]    core_in_fall;
  logic [1:0]    core_out;
  logic [1:0]    io_out;
  logic [1:0]    io_out_oeb;
  logic [63:0]   fanout_in;
  logic [255:0]  fanout_out;

  int checks;
  int errors;

  io_control_router_if la_if ();

  io_control_router #(
    .NUM_BANKS   (NB),
    .PIPE_STAGES (PS)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .la           (la_if),
    .io_in        (io_in),
    .io_in_oeb    (io_in_oeb),
    .core_in      (core_in),
    .core_in_rise (core_in_rise),
    .core_in_fall (core_in_fall),
    .core_out     (core_out),
    .io_out       (io_out),
    .io_out_oeb   (io_out_oeb),
    .fanout_in    (fanout_in),
    .fanout_out   (fanout_out)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one active edge and land 1 time unit after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic seen;
    checks = 0;
    errors = 0;

    reset_n          = 1'b0;
    io_in            = 5'h10;
    la_if.la_oenb    = '1;
    la_if.la_data_in = '0;
    core_out         = 2'b00;
    fanout_in        = '0;
    repeat (2) tick();

    check("rst_io_in_oeb",  io_in_oeb,    5'h1F);
    check("rst_io_out_oeb", io_out_oeb,   2'b00);
    check("rst_io_out",     io_out,       2'b00);
    check("rst_core_in",    core_in,      5'h10);
    check("rst_rise",       core_in_rise, 5'h00);
    check("rst_fall",       core_in_fall, 5'h00);
    check("rst_fanout",     fanout_out,   256'h0);

    reset_n = 1'b1;
    repeat (8) tick();
    check("idle_core_in", core_in, 5'h10);

    // Filtered step on input 0: accepted on edge 6.
    io_in[0] = 1'b1;
    repeat (5) tick();
    check("step0_e5_core", core_in[0], 1'b0);
    tick();
    check("step0_e6_core", core_in[0], 1'b1);
    check("step0_e6_rise", core_in_rise, 5'h01);
    tick();
    check("step0_e7_rise", core_in_rise[0], 1'b0);
    check("step0_e7_core", core_in[0], 1'b1);

    // Two-cycle glitch on filtered input 1 must be swallowed.
    io_in[1] = 1'b1;
    repeat (2) tick();
    io_in[1] = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      seen = seen | core_in[1] | core_in_rise[1] | core_in_fall[1];
    end
    check("glitch1_blocked", seen, 1'b0);

    // Same glitch on unfiltered input 2 passes through: rise at 4, fall at 6.
    io_in[2] = 1'b1;
    repeat (2) tick();
    io_in[2] = 1'b0;
    tick();
    check("glitch2_e3_core", core_in[2], 1'b0);
    tick();
    check("glitch2_e4_core", core_in[2], 1'b1);
    check("glitch2_e4_rise", core_in_rise, 5'h04);
    tick();
    check("glitch2_e5_core", core_in[2], 1'b1);
    check("glitch2_e5_rise", core_in_rise[2], 1'b0);
    tick();
    check("glitch2_e6_core", core_in[2], 1'b0);
    check("glitch2_e6_fall", core_in_fall, 5'h04);
    tick();
    check("glitch2_e7_fall", core_in_fall[2], 1'b0);

    // LA value override on input 1 while the pad stays low.
    la_if.la_oenb[33]    = 1'b0;
    la_if.la_data_in[33] = 1'b1;
    repeat (3) tick();
    check("la_in_e3_core", core_in[1], 1'b0);
    tick();
    check("la_in_e4_core", core_in[1], 1'b1);
    check("la_in_e4_rise", core_in_rise[1], 1'b1);
    la_if.la_oenb[33] = 1'b1;
    repeat (3) tick();
    check("la_rel_e3_core", core_in[1], 1'b1);
    tick();
    check("la_rel_e4_core", core_in[1], 1'b0);
    check("la_rel_e4_fall", core_in_fall[1], 1'b1);

    // Output path and OEB overrides, each registered once.
    core_out = 2'b10;
    tick();
    check("io_out_core", io_out, 2'b10);
    la_if.la_oenb[0]     = 1'b0;
    la_if.la_data_in[0]  = 1'b0;
    la_if.la_oenb[16]    = 1'b0;
    la_if.la_data_in[16] = 1'b1;
    la_if.la_oenb[48]    = 1'b0;
    la_if.la_data_in[48] = 1'b1;
    la_if.la_oenb[49]    = 1'b0;
    la_if.la_data_in[49] = 1'b0;
    #1;
    check("ovr_pre_in_oeb", io_in_oeb, 5'h1F);
    check("ovr_pre_io_out", io_out, 2'b10);
    tick();
    check("ovr_in_oeb",  io_in_oeb,  5'h1E);
    check("ovr_out_oeb", io_out_oeb, 2'b01);
    check("ovr_io_out",  io_out,     2'b01);
    la_if.la_oenb    = '1;
    la_if.la_data_in = '0;
    tick();
    check("rel_in_oeb",  io_in_oeb,  5'h1F);
    check("rel_out_oeb", io_out_oeb, 2'b00);
    check("rel_io_out",  io_out,     2'b10);

    // One-cycle word through the 3-deep, 4-bank fanout.
    fanout_in = FAN;
    tick();
    fanout_in = '0;
    check("fan_e1", fanout_out, 256'h0);
    tick();
    check("fan_e2", fanout_out, 256'h0);
    tick();
    check("fan_e3", fanout_out, {NB{FAN}});
    tick();
    check("fan_e4", fanout_out, 256'h0);

    // Reset in the middle of a filter count restarts the full latency.
    io_in[0] = 1'b0;
    repeat (6) tick();
    check("pre_rst_fall_core", core_in[0], 1'b0);
    io_in[0] = 1'b1;
    repeat (5) tick();
    check("pre_rst_e5_core", core_in[0], 1'b0);
    reset_n = 1'b0;
    #1;
    check("mid_rst_core", core_in, 5'h10);
    check("mid_rst_rise", core_in_rise, 5'h00);
    tick();
    reset_n = 1'b1;
    repeat (5) tick();
    check("post_rst_e5_core", core_in[0], 1'b0);
    tick();
    check("post_rst_e6_core", core_in[0], 1'b1);
    check("post_rst_e6_rise", core_in_rise, 5'h01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/io_control_router.md
# io_control_router

Parametrised pad/logic-analyzer routing block that sits between the user IO pads and the motor-sequencer core. It generalises the registered LA-override muxing to NUM_IN inputs and NUM_OUT outputs. Each input gets a multi-stage synchronizer, a per-channel glitch filter and edge pulses. A core bus is fanned out to NUM_BANKS replicated register pipelines, so drivers on the left and right halves each get their own copy.

## Interface
Parameters:
- NUM_IN, 5: pad inputs (latch_data, control_trigger, sclk, mosi, ss_n); 1..16
- NUM_OUT, 2: pad outputs (update_cycle_complete, miso); 1..16
- SYNC_STAGES, 2: synchronizer depth; >=2
- FILTER_LEN, 3: consecutive stable cycles required by filtered channels; >=1
- FILTER_MASK, 5'b00011: bit i=1 filters input i; bit i=0 means input i behaves as FILTER_LEN=1
- IN_RESET_VAL, 5'b10000: reset value of core_in (ss_n idles high)
- FANOUT_W, 64: fanout bus width
- NUM_BANKS, 2: fanout replicas
- PIPE_STAGES, 1: fanout register depth; >=1

Ports (clock and reset first):
- clock  in  1  single clock domain; all state on posedge
- reset_n  in  1  asynchronous, active-low; clears all state
- la_data_in  in  128  LA values
- la_oenb  in  128  LA enables, active-low
- io_in  in  NUM_IN  raw pad inputs, asynchronous
- io_in_oeb  out  NUM_IN  pad OEB for inputs
- core_in  out  NUM_IN  synchronized, filtered inputs
- core_in_rise  out  NUM_IN  1-cycle pulse on a core_in 0->1 transition
- core_in_fall  out  NUM_IN  1-cycle pulse on a core_in 1->0 transition
- core_out  in  NUM_OUT  core-generated outputs
- io_out  out  NUM_OUT  pad output values
- io_out_oeb  out  NUM_OUT  pad OEB for outputs
- fanout_in  in  FANOUT_W  core bus
- fanout_out  out  NUM_BANKS*FANOUT_W  bank b occupies bits [b*FANOUT_W +: FANOUT_W]

## Operation
- LA map: bit 0+i overrides io_in_oeb[i]; bit 16+j overrides io_out_oeb[j]; bit 32+i overrides the input value; bit 48+j overrides io_out[j]. A lane is in override when ~la_oenb[k]; the override value is la_data_in[k].
- io_in_oeb[i] = override ? LA bit : 1. io_out_oeb[j] = override ? LA bit : 0. io_out[j] = override ? LA bit : core_out[j]. All three are registered.
- Input i:
  - sync chain of SYNC_STAGES flops.
  - s_q <= override ? la_data_in[32+i] : sync_out. The override path bypasses the synchronizer.
  - Filter counter cnt, width $clog2(FILTER_LEN+1):
    - if s_q == core_in: cnt <= 0.
    - else if cnt == FILTER_LEN-1: core_in <= s_q, cnt <= 0, and the matching rise or fall pulse is asserted.
    - else: cnt <= cnt+1.
- Pulses register alongside core_in and are high for exactly one cycle.
- A glitch on s_q shorter than FILTER_LEN cycles never reaches core_in. A return to the core_in value mid-count clears cnt.
- Fanout: every bank is an independent chain of PIPE_STAGES registers fed from fanout_in. Banks must not share final flops; synthesis keep attribute required.
- Parameter violations cause an elaboration-time $error.

## Timing
- Reset values: io_in_oeb all 1; io_out_oeb 0; io_out 0; core_in = IN_RESET_VAL; rise/fall 0; sync and s_q flops = IN_RESET_VAL; cnt 0; fanout_out 0.
- Pad step before edge 0 -> core_in and pulse change at edge SYNC_STAGES+1+FILTER_LEN (6 with defaults; 4 for unfiltered channels).
- LA override value step -> core_in changes at edge 1+FILTER_LEN.
- OEB, io_out and override-select changes take effect at the next edge.
- fanout_out = fanout_in delayed PIPE_STAGES cycles, identical across banks.
- Asserting reset_n low mid-filter or mid-pipe clears state immediately. The first update after release follows the latencies above.

## Structure
- Package io_router_pkg holds the LA base constants (0, 16, 32, 48), the limit checks, and the FANOUT bank slicing function.
- Sub-module io_sync_filter, one instance per input, contains sync, s_q, cnt, core_in and the edge pulses. Parameters: SYNC_STAGES, FILTER_LEN, RESET_VAL.

## Test plan
- Reset with reset_n=0 -> io_in_oeb=5'h1F, io_out_oeb=0, core_in=5'h10, fanout_out=0, no pulses.
- Step io_in[0] 0->1 and hold -> core_in[0]=1 at edge 6, core_in_rise[0] high exactly at edge 6.
- 2-cycle pulse on io_in[1] (filtered) -> core_in[1] unchanged, no pulses. Same pulse on io_in[2] -> core_in[2] toggles twice with rise then fall.
- la_oenb[33]=0, la_data_in[33]=1 while io_in[1]=0 -> core_in[1]=1 at edge 4. Releasing la_oenb[33] -> falls back to pad value.
- fanout_in=64'hDEADBEEF_01234567 for one cycle, PIPE_STAGES=3, NUM_BANKS=4 -> all four banks show the value at edge 3 only.
- reset_n pulsed low with cnt=2 -> cnt=0, and a subsequent stable change needs a full FILTER_LEN again.
